// File: rtl/add8_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add8_stats_pkg                                                        |
// | Shared widths and sequencer states for the adder error statistics.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package add8_stats_pkg;

  localparam int C_OP_W  = 8;
  localparam int C_RES_W = 9;
  localparam int C_ERR_W = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add8_abs_err.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add8_abs_err                                                          |
// | Absolute difference between the exact 9-bit sum and a result under   |
// | test.                                                                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module add8_abs_err
  import add8_stats_pkg::*;
(
  input  logic [C_OP_W-1:0]  in_a,
  input  logic [C_OP_W-1:0]  in_b,
  input  logic [C_RES_W-1:0] in_o,
  output logic [C_ERR_W-1:0] err
);

  logic [C_RES_W-1:0] w_exact;

  assign w_exact = {1'b0, in_a} + {1'b0, in_b};
  assign err     = (w_exact >= in_o) ? (w_exact - in_o) : (in_o - w_exact);

endmodule
`default_nettype wire

// File: rtl/add8_err_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add8_err_stats                                                        |
// | Accumulates sum, maximum and count of adder errors over a run.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module add8_err_stats
  import add8_stats_pkg::*;
#(
  parameter int N_W   = 16,
  parameter int SUM_W = N_W + 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_W-1:0]     n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [C_OP_W-1:0]  in_a,
  input  logic [C_OP_W-1:0]  in_b,
  input  logic [C_RES_W-1:0] in_o,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum_abs_err,
  output logic [C_ERR_W-1:0] max_err,
  output logic [N_W-1:0]     err_cnt
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_W-1:0]       r_remaining;
  logic [C_ERR_W-1:0]   w_err;
  logic [C_ERR_W-1:0]   r_err;
  logic                 r_err_vld;
  logic [SUM_W-1:0]     r_sum;
  logic [C_ERR_W-1:0]   r_max;
  logic [N_W-1:0]       r_cnt;
  logic                 w_start_acc;
  logic                 w_accept;
  logic                 w_last;

  add8_abs_err u_abs_err (
    .in_a (in_a),
    .in_b (in_b),
    .in_o (in_o),
    .err  (w_err)
  );

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign in_ready    = (r_state == S_RUN) && (r_remaining != '0);
  assign w_accept    = in_valid && in_ready;
  assign w_last      = w_accept && (r_remaining == N_W'(1));

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign sum_abs_err = r_sum;
  assign max_err     = r_max;
  assign err_cnt     = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (n_samples == '0) ? S_FLUSH : S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_FLUSH;
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // One-stage error pipeline; FLUSH exists to let its last entry commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_err       <= '0;
      r_err_vld   <= 1'b0;
    end else begin
      r_err_vld <= w_accept;
      if (w_accept) r_err <= w_err;
      if (w_start_acc)   r_remaining <= n_samples;
      else if (w_accept) r_remaining <= r_remaining - N_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_sum <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else if (r_err_vld) begin
      r_sum <= r_sum + SUM_W'(r_err);
      if (r_err > r_max) r_max <= r_err;
      r_cnt <= r_cnt + {{(N_W-1){1'b0}}, (r_err != '0)};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add8_err_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_add8_err_stats                                                     |
// | Randomized and directed runs scored against a queue of run results.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_add8_err_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] n_samples;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [8:0]  in_o;
  logic        busy;
  logic        done;
  logic [24:0] sum_abs_err;
  logic [8:0]  max_err;
  logic [15:0] err_cnt;

  add8_err_stats dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_samples   (n_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_o        (in_o),
    .busy        (busy),
    .done        (done),
    .sum_abs_err (sum_abs_err),
    .max_err     (max_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    longint mx;
    longint cnt;
    longint due;
  } exp_t;

  exp_t   exp_q[$];
  int     sa[$];
  int     sb[$];
  int     so[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum_abs_err", sum_abs_err, e.sum);
        chk("max_err", max_err, e.mx);
        chk("err_cnt", err_cnt, e.cnt);
        if (e.due >= 0) chk("done_latency", cyc, e.due);
      end
    end
  end

  function automatic exp_t model(input int upto);
    exp_t e;
    e.sum = 0; e.mx = 0; e.cnt = 0; e.due = -1;
    for (int i = 0; i < upto; i++) begin
      int d;
      d = sa[i] + sb[i] - so[i];
      if (d < 0) d = -d;
      e.sum += d;
      if (d > e.mx) e.mx = d;
      if (d != 0) e.cnt++;
    end
    return e;
  endfunction

  task automatic add(input int a, input int b, input int o);
    sa.push_back(a); sb.push_back(b); so.push_back(o);
  endtask

  task automatic clear_samples();
    sa.delete(); sb.delete(); so.delete();
  endtask

  // Called just after an active edge; runs one measurement, optionally aborted by reset.
  task automatic run(input int gap_min, input int gap_max, input bit mid_start, input int abort_at);
    int   n;
    exp_t e;
    bit   got;
    n = sa.size();
    e = model(n);
    if (gap_max == 0) e.due = cyc + n + 2;
    if (abort_at < 0) exp_q.push_back(e);
    start = 1'b1;
    n_samples = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    n_samples = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) begin
        exp_t p;
        p = model(i);
        @(posedge clk); #1;
        chk("partial_sum", sum_abs_err, p.sum);
        #2 rst = 1'b1;
        #1;
        chk("rst_sum", sum_abs_err, 0);
        chk("rst_max", max_err, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      in_valid = 1'b1;
      in_a = 8'(sa[i]); in_b = 8'(sb[i]); in_o = 9'(so[i]);
      got = 1'b0;
      for (int w = 0; w < 30 && !got; w++) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk); #1;
      end
      if (!got) chk("handshake_timeout", 0, 1);
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_o = 9'($urandom);
      begin
        int g;
        g = (gap_max == 0) ? 0 : $urandom_range(gap_max, gap_min);
        for (int k = 0; k < g; k++) begin
          if (mid_start && i == 0 && k == 1) begin
            start = 1'b1;
            n_samples = 16'($urandom_range(1, 9));
          end
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    begin
      bit finished;
      finished = 1'b0;
      for (int w = 0; w < 60 && !finished; w++) begin
        @(negedge clk);
        if (n == 0) chk("ready_n0", in_ready, 0);
        if (!busy) finished = 1'b1;
      end
      if (!finished) chk("run_timeout", busy, 0);
    end
    // Idle traffic must be ignored and results must hold.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_o = 9'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("hold_sum", sum_abs_err, e.sum);
    chk("hold_max", max_err, e.mx);
    chk("hold_cnt", err_cnt, e.cnt);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_o = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", in_ready, 0);
    chk("reset_sum", sum_abs_err, 0);
    chk("reset_max", max_err, 0);
    chk("reset_cnt", err_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    clear_samples();
    repeat (4) add(10, 20, 30);
    run(0, 0, 1'b0, -1);

    clear_samples();
    add(255, 255, 492); add(16, 16, 40); add(1, 2, 3);
    run(0, 0, 1'b0, -1);

    clear_samples();
    run(0, 0, 1'b0, -1);

    clear_samples();
    add(100, 50, 140); add(7, 9, 20);
    run(5, 5, 1'b1, -1);

    clear_samples();
    add(3, 4, 10); add(200, 1, 190); add(5, 5, 10); add(1, 1, 2); add(9, 9, 18);
    run(0, 0, 1'b0, 2);
    clear_samples();
    add(0, 0, 5);
    run(0, 0, 1'b0, -1);

    clear_samples();
    add(0, 0, 511); add(255, 255, 0);
    run(0, 0, 1'b0, -1);

    for (int r = 0; r < 10; r++) begin
      int n;
      clear_samples();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        int a, b, o, mode;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        mode = $urandom_range(0, 2);
        if (mode == 0)      o = a + b;
        else if (mode == 1) o = a + b + $urandom_range(0, 20) - 10;
        else                o = $urandom_range(0, 511);
        if (o < 0) o = 0;
        if (o > 511) o = 511;
        add(a, b, o);
      end
      if (r % 2 == 0) run(0, 0, 1'b0, -1);
      else            run(0, 3, 1'b0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_runs", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
